// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states, line levels and the
// parity helper used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } uart_rx_state_t;

  localparam logic IDLE_VAL  = 1'b1;
  localparam logic START_VAL = 1'b0;

  // Reserved encoding 3 behaves as no parity.
  function automatic parity_t decode_parity(input logic [1:0] mode);
    parity_t p;
    case (mode)
      2'd1:    p = PARITY_EVEN;
      2'd2:    p = PARITY_ODD;
      default: p = PARITY_NONE;
    endcase
    return p;
  endfunction

  // Expected parity bit over the low nbits of data.
  function automatic logic calc_parity(input logic [15:0] data, input logic [3:0] nbits,
                                       input parity_t mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(nbits)) p = p ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divisor: emits a one-clk tick every baud_div cycles (0 behaves as 1).
// restart holds the count at zero so the first tick lands a full period later.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             run,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last;

  assign last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick = run && !restart && (cnt_q == last);

  // Next count: clear on restart or at end of period, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with runtime data width, parity and stop-bit
// configuration. Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// majority of the last three sample ticks instead of a single centre sample.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     en,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [3:0]               data_bits,
  input  logic [1:0]               parity_mode,
  input  logic                     stop_bits,
  output logic [MAX_DATA_BITS-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       MaxBits  = 4'(MAX_DATA_BITS);

  uart_rx_state_t state_q, state_d;
  logic                     rx_meta_q, rxs;
  logic [CNT_W-1:0]         s_cnt_q, s_cnt_d;
  logic [3:0]               idx_q, idx_d;
  logic [3:0]               nbits_q, nbits_d;
  parity_t                  pmode_q, pmode_d;
  logic                     two_stop_q, two_stop_d;
  logic [MAX_DATA_BITS-1:0] data_q, data_d;
  logic                     perr_q, perr_d, ferr_q, ferr_d;
  logic                     need_high_q, need_high_d;
  logic                     done_q, done_d;
  logic                     tick, samp;
  logic [MAX_DATA_BITS-1:0] out_data_q;
  logic                     out_valid_q, parity_err_q, frame_err_q, overrun_q;

  // Two-flop synchroniser for the asynchronous line, reset to idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= IDLE_VAL;
      rxs       <= IDLE_VAL;
    end else begin
      rx_meta_q <= rx;
      rxs       <= rx_meta_q;
    end
  end

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q == StIdle),
    .run     (state_q != StIdle),
    .baud_div(baud_div),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // History of the two previous sample ticks for the majority vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       hist_q <= {IDLE_VAL, IDLE_VAL};
    else if (tick) hist_q <= {hist_q[0], rxs};
  end

  assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign samp = rxs;
`endif

  // Frame FSM: start detection, bit sampling, error collection.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    idx_d       = idx_q;
    nbits_d     = nbits_q;
    pmode_d     = pmode_q;
    two_stop_d  = two_stop_q;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    need_high_d = need_high_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // After a low stop bit (e.g. a break) the line must go high before re-arming.
        if (rxs == IDLE_VAL) need_high_d = 1'b0;
        if (en && rxs == START_VAL && !need_high_q) begin
          nbits_d    = (data_bits < 4'd5 || data_bits > MaxBits) ? MaxBits : data_bits;
          pmode_d    = decode_parity(parity_mode);
          two_stop_d = stop_bits;
          s_cnt_d    = '0;
          idx_d      = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_cnt_q == HalfLast) begin
            s_cnt_d = '0;
            state_d = (samp == IDLE_VAL) ? StIdle : StData;
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          // Power-of-two oversample: the increment wraps to 0 after BitLast.
          s_cnt_d = s_cnt_q + CNT_W'(1);
          if (s_cnt_q == BitLast) begin
            unique case (state_q)
              StData: begin
                for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
                  if (4'(i) == idx_q) data_d[i] = samp;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == nbits_q - 4'd1) begin
                  state_d = (pmode_q != PARITY_NONE) ? StParity : StStop1;
                end
              end
              StParity: begin
                if (samp != calc_parity(16'(data_q), nbits_q, pmode_q)) perr_d = 1'b1;
                state_d = StStop1;
              end
              StStop1: begin
                if (samp == START_VAL) ferr_d = 1'b1;
                if (two_stop_q) begin
                  state_d = StStop2;
                end else begin
                  state_d     = StIdle;
                  done_d      = 1'b1;
                  need_high_d = (samp == START_VAL);
                end
              end
              default: begin
                if (samp == START_VAL) ferr_d = 1'b1;
                state_d     = StIdle;
                done_d      = 1'b1;
                need_high_d = (samp == START_VAL);
              end
            endcase
          end
        end
      end
    endcase
  end

  // Frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      s_cnt_q     <= '0;
      idx_q       <= '0;
      nbits_q     <= MaxBits;
      pmode_q     <= PARITY_NONE;
      two_stop_q  <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      need_high_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      idx_q       <= idx_d;
      nbits_q     <= nbits_d;
      pmode_q     <= pmode_d;
      two_stop_q  <= two_stop_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      need_high_q <= need_high_d;
      done_q      <= done_d;
    end
  end

  // Output holding register: load on completion if free or being accepted, else flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        if (!out_valid_q || out_ready) begin
          out_data_q   <= data_q;
          parity_err_q <= perr_q;
          frame_err_q  <= ferr_q;
          out_valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: the stimulus side pushes expected frames,
// a negedge monitor pops and compares every accepted output beat.
module tb_uart_rx_os;

  localparam int BitClk = 64;  // baud_div 4 * oversample 16

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       en = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity_mode = 2'd0;
  logic       stop_bits = 1'b0;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       parity_err, frame_err, overrun, busy;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   ov_cnt = 0;

  uart_rx_os dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .en         (en),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: compare every accepted beat against the head of the queue.
  always @(negedge clk) begin
    if (!rst && overrun) ov_cnt++;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got data=%h pe=%b fe=%b, required no frame",
                 out_data, parity_err, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.d || parity_err !== mon_e.pe || frame_err !== mon_e.fe) begin
          bad++;
          $display("FAIL frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                   out_data, parity_err, frame_err, mon_e.d, mon_e.pe, mon_e.fe);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic line_bit(input logic b);
    rx = b;
    repeat (BitClk) @(posedge clk);
  endtask

  // One frame on the wire: start, nb data bits LSB first, optional parity, stop bits.
  task automatic send(input logic [8:0] d, input int nb, input int pm, input bit flip,
                      input logic stop_v, input int nstop);
    logic par;
    par = 1'b0;
    line_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      line_bit(d[i]);
      par = par ^ d[i];
    end
    if (pm == 1 || pm == 2) begin
      if (pm == 2) par = ~par;
      if (flip) par = ~par;
      line_bit(par);
    end
    for (int i = 0; i < nstop; i++) line_bit(stop_v);
  endtask

  task automatic push(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d frames pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 1: 8N1 0xA5
    push(9'h0A5, 1'b0, 1'b0);
    send(9'h0A5, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    wait_drain("t1_drain");

    // 2: 7E2, wrong parity then correct parity
    data_bits = 4'd7; parity_mode = 2'd1; stop_bits = 1'b1;
    push(9'h035, 1'b1, 1'b0);
    send(9'h035, 7, 1, 1'b1, 1'b1, 2);
    line_bit(1'b1);
    push(9'h035, 1'b0, 1'b0);
    send(9'h035, 7, 1, 1'b0, 1'b1, 2);
    line_bit(1'b1);
    wait_drain("t2_drain");
    data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0;

    // 3: start glitch of 4 ticks, then disabled receiver, then a real frame
    rx = 1'b0;
    repeat (16) @(posedge clk);
    rx = 1'b1;
    repeat (BitClk) @(posedge clk);
    check("t3_busy_after_glitch", 32'(busy), 32'd0);
    en = 1'b0;
    send(9'h099, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    check("t3_busy_disabled", 32'(busy), 32'd0);
    en = 1'b1;
    push(9'h05A, 1'b0, 1'b0);
    send(9'h05A, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    wait_drain("t3_drain");

    // 4: stop bit low, then a held-low break, then 0x81
    push(9'h03C, 1'b0, 1'b1);
    send(9'h03C, 8, 0, 1'b0, 1'b0, 1);
    line_bit(1'b1);
    push(9'h000, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (40 * BitClk) @(posedge clk);
    line_bit(1'b1);
    line_bit(1'b1);
    push(9'h081, 1'b0, 1'b0);
    send(9'h081, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    wait_drain("t4_drain");

    // 5: consumer stalled, two back-to-back frames
    @(posedge clk); #1 out_ready = 1'b0;
    ov_cnt = 0;
    push(9'h011, 1'b0, 1'b0);
    send(9'h011, 8, 0, 1'b0, 1'b1, 1);
    send(9'h022, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    check("t5_held_data", 32'(out_data), 32'h011);
    check("t5_held_valid", 32'(out_valid), 32'd1);
    check("t5_overrun_pulses", 32'(ov_cnt), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t5_valid_dropped", 32'(out_valid), 32'd0);
    wait_drain("t5_drain");

    // 6: held frame, then reset during data bit 3 of the next frame
    @(posedge clk); #1 out_ready = 1'b0;
    send(9'h077, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b1);
    line_bit(1'b0);
    rx = 1'b0;
    repeat (BitClk / 2) @(posedge clk);
    check("t6_busy_mid", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    line_bit(1'b1);
    push(9'h0C3, 1'b0, 1'b0);
    send(9'h0C3, 8, 0, 1'b0, 1'b1, 1);
    line_bit(1'b1);
    wait_drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
